// File: rtl/ram_rmw_client_pkg.sv
// rtl/ram_rmw_client_pkg.sv - shared op encodings for the state-RAM read-modify-write client
package ram_rmw_client_pkg;

    localparam int RAM_OP_W = 2;

    typedef enum logic [RAM_OP_W-1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_ADD   = 2'd2,
        OP_RSVD  = 2'd3
    } ram_op_e;

    // Reserved encodings fall through to READ behaviour: no RAM write.
    function automatic logic op_writes(input ram_op_e op);
        return (op == OP_WRITE) || (op == OP_ADD);
    endfunction

endpackage

// File: rtl/ram_rmw_client_sync_fifo.sv
// rtl/ram_rmw_client_sync_fifo.sv - single-clock FIFO, output driven only from flops
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic                     rd_val_o,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok  = push_i & (cnt_q != FULL);
        pop_ok   = pop_i & (cnt_q != '0);
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: nothing is observable until the count says so.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_comb begin
        rd_val_o  = (cnt_q != '0);
        rd_data_o = rd_val_o ? mem_q[rd_ptr_q] : '0;
        count_o   = cnt_q;
    end

endmodule

// File: rtl/ram_rmw_client.sv
// rtl/ram_rmw_client.sv - READ/WRITE/ADD initiator for one read/write port pair of the state RAM
module ram_rmw_client
    import ram_rmw_client_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 10,
    parameter int RAM_DATA_WIDTH = 32,
    parameter int RESP_DEPTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_val_i,
    output logic                      req_rdy_o,
    input  logic [RAM_OP_W-1:0]       req_op_i,
    input  logic [RAM_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [RAM_DATA_WIDTH-1:0] req_data_i,
    output logic                      resp_val_o,
    input  logic                      resp_rdy_i,
    output logic [RAM_DATA_WIDTH-1:0] resp_data_o,
    output logic                      r_val_o,
    output logic [RAM_ADDR_WIDTH-1:0] r_addr_o,
    input  logic [RAM_DATA_WIDTH-1:0] r_data_i,
    output logic                      w_val_o,
    output logic [RAM_ADDR_WIDTH-1:0] w_addr_o,
    output logic [RAM_DATA_WIDTH-1:0] w_data_o
);

    localparam int CW = $clog2(RESP_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(RESP_DEPTH);

    logic                      s1_v_q, s1_v_d;
    ram_op_e                   s1_op_q, s1_op_d;
    logic [RAM_ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic [RAM_DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                      fwd_hit_q, fwd_hit_d;
    logic [RAM_DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

    logic                      accept;
    logic                      s1_writes;
    logic [CW-1:0]             fifo_cnt;
    logic [CW:0]               credits_used;
    logic [RAM_DATA_WIDTH-1:0] old_val, new_val;

    // Credit counts the data-stage entry too, so the FIFO can never overflow.
    // The same-cycle pop is deliberately ignored to keep resp_rdy off the req_rdy path.
    always_comb begin
        credits_used = {1'b0, fifo_cnt} + (CW+1)'(s1_v_q);
        req_rdy_o    = rst_ni & (credits_used < CREDITS);
        accept       = req_val_i & req_rdy_o;
    end

    // The RAM read issued at accept lands now, unless the previous op wrote this address.
    always_comb begin
        old_val   = fwd_hit_q ? fwd_data_q : r_data_i;
        s1_writes = op_writes(s1_op_q);
        case (s1_op_q)
            OP_WRITE: new_val = s1_data_q;
            OP_ADD:   new_val = old_val + s1_data_q;
            default:  new_val = old_val;
        endcase
    end

    always_comb begin
        s1_v_d     = accept;
        s1_op_d    = s1_op_q;
        s1_addr_d  = s1_addr_q;
        s1_data_d  = s1_data_q;
        fwd_hit_d  = fwd_hit_q;
        fwd_data_d = fwd_data_q;
        if (accept) begin
            s1_op_d    = ram_op_e'(req_op_i);
            s1_addr_d  = req_addr_i;
            s1_data_d  = req_data_i;
            fwd_hit_d  = s1_v_q & s1_writes & (s1_addr_q == req_addr_i);
            fwd_data_d = new_val;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v_q     <= 1'b0;
            s1_op_q    <= OP_READ;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_op_q    <= s1_op_d;
            s1_addr_q  <= s1_addr_d;
            s1_data_q  <= s1_data_d;
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    always_comb begin
        r_val_o  = accept;
        r_addr_o = accept ? req_addr_i : '0;
        w_val_o  = s1_v_q & s1_writes;
        w_addr_o = w_val_o ? s1_addr_q : '0;
        w_data_o = w_val_o ? new_val : '0;
    end

    sync_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (RAM_DATA_WIDTH)
    ) u_resp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (s1_v_q),
        .push_data_i (old_val),
        .pop_i       (resp_rdy_i),
        .rd_val_o    (resp_val_o),
        .rd_data_o   (resp_data_o),
        .count_o     (fifo_cnt)
    );

endmodule

// File: tb/tb_ram_rmw_client.sv
// tb/tb_ram_rmw_client.sv - directed and scoreboarded bench for ram_rmw_client with a 1-cycle RAM model
module tb_ram_rmw_client;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam logic [1:0] RD = 2'd0, WR = 2'd1, AD = 2'd2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_val, req_rdy;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          resp_val, resp_rdy;
    logic [DW-1:0] resp_data;
    logic          r_val, w_val;
    logic [AW-1:0] r_addr, w_addr;
    logic [DW-1:0] r_data, w_data;

    logic [DW-1:0] mem [1024];
    logic [DW-1:0] got_q [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] sb [4];
    int compared = 0, mismatched = 0;
    int wcount = 0, rdy_bad = 0, stalls = 0;
    int base, w0, acc;
    bit done;

    always #5 clk = ~clk;

    ram_rmw_client #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .RESP_DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_val_i(req_val), .req_rdy_o(req_rdy), .req_op_i(req_op),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .resp_val_o(resp_val), .resp_rdy_i(resp_rdy), .resp_data_o(resp_data),
        .r_val_o(r_val), .r_addr_o(r_addr), .r_data_i(r_data),
        .w_val_o(w_val), .w_addr_o(w_addr), .w_data_o(w_data)
    );

    // RAM model: preload, then 1-cycle read latency, read returns pre-write contents.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[3] = 32'd7;
        mem[9] = 32'hFFFF_FFFF;
        for (int i = 0; i < 8; i++) mem[20+i] = 32'h100 + i;
        for (int i = 0; i < 4; i++) mem[40+i] = 32'hFFFF_FFF0 + i;
        r_data = '0;
        forever begin
            @(posedge clk);
            if (r_val) r_data <= mem[r_addr];
            if (w_val) mem[w_addr] <= w_data;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && resp_val && resp_rdy) got_q.push_back(resp_data);
            if (w_val) wcount++;
            if (!rst_n && req_rdy) rdy_bad++;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        req_val = 1'b0; req_op = RD; req_addr = '0; req_data = '0;
    endtask

    // Called at a negedge; returns at the negedge after the request was accepted.
    task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int waited = 0;
        req_val = 1'b1; req_op = op; req_addr = a; req_data = d;
        #1;
        while (!req_rdy && waited < 50) begin
            @(negedge clk); #1; waited++;
        end
        chk("send_rdy", {31'd0, req_rdy}, 32'd1);
        stalls += waited;
        @(negedge clk);
    endtask

    task automatic wait_resps(input int n);
        int k = 0;
        while (got_q.size() < base + n && k < 200) begin
            @(negedge clk); k++;
        end
        chk("resp_count", got_q.size(), base + n);
    endtask

    initial begin
        rst_n = 1'b0; resp_rdy = 1'b1;
        req_val = 1'b1; req_op = WR; req_addr = 10'h155; req_data = 32'hDEAD_BEEF;
        @(negedge clk); #1;
        chk("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
        chk("rst_r_val", {31'd0, r_val}, 32'd0);
        chk("rst_r_addr", {22'd0, r_addr}, 32'd0);
        chk("rst_w_val", {31'd0, w_val}, 32'd0);
        chk("rst_w_addr", {22'd0, w_addr}, 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_resp_val", {31'd0, resp_val}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_rdy", {31'd0, req_rdy}, 32'd1);
        @(negedge clk);

        // WRITE then READ back-to-back on A=5.
        base = got_q.size(); w0 = wcount;
        send(WR, 10'd5, 32'h10);
        send(RD, 10'd5, 32'h0);
        idle();
        wait_resps(2);
        chk("wr_old", got_q[base], 32'h0);
        chk("rd_new", got_q[base+1], 32'h10);
        @(negedge clk);
        chk("wr_pulses", wcount - w0, 32'd1);
        chk("ram5", mem[5], 32'h10);

        // Four back-to-back ADDs on A=3 exercise forwarding.
        base = got_q.size(); stalls = 0;
        for (int i = 0; i < 4; i++) send(AD, 10'd3, 32'd1);
        idle();
        chk("add_no_stall", stalls, 32'd0);
        wait_resps(4);
        chk("add_r0", got_q[base],   32'd7);
        chk("add_r1", got_q[base+1], 32'd8);
        chk("add_r2", got_q[base+2], 32'd9);
        chk("add_r3", got_q[base+3], 32'd10);
        @(negedge clk);
        chk("ram3", mem[3], 32'd11);

        // ADD wraps with carry dropped.
        base = got_q.size();
        send(AD, 10'd9, 32'd1);
        idle();
        wait_resps(1);
        chk("wrap_old", got_q[base], 32'hFFFF_FFFF);
        @(negedge clk);
        chk("ram9", mem[9], 32'd0);

        // Back-pressure: only RESP_DEPTH reads get in.
        base = got_q.size(); acc = 0;
        resp_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_val = 1'b1; req_op = RD; req_addr = AW'(20 + acc); req_data = '0;
            #1;
            if (req_rdy) acc++;
            @(negedge clk);
        end
        idle();
        #1;
        chk("full_accepts", acc, 32'd4);
        chk("full_rdy", {31'd0, req_rdy}, 32'd0);
        chk("full_resp_val", {31'd0, resp_val}, 32'd1);
        chk("full_hold_data", resp_data, 32'h100);
        chk("full_no_pop", got_q.size(), base);
        @(negedge clk);
        resp_rdy = 1'b1;
        #1 chk("pop_rdy_same", {31'd0, req_rdy}, 32'd0);
        @(negedge clk);
        #1 chk("pop_rdy_next", {31'd0, req_rdy}, 32'd1);
        wait_resps(4);
        for (int i = 0; i < 4; i++) chk("full_order", got_q[base+i], 32'h100 + i);
        repeat (3) @(negedge clk);
        chk("full_no_dup", got_q.size(), base + 4);

        // Reset with a WRITE in the data stage drops the write.
        send(WR, 10'd5, 32'h55);
        idle();
        #1;
        chk("mid_w_val", {31'd0, w_val}, 32'd1);
        chk("mid_w_data", w_data, 32'h55);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_w_val", {31'd0, w_val}, 32'd0);
        chk("mid_rst_w_data", w_data, 32'd0);
        chk("mid_rst_rdy", {31'd0, req_rdy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("mid_ram5", mem[5], 32'h10);
        @(negedge clk);
        base = got_q.size();
        send(RD, 10'd5, 32'h0);
        idle();
        wait_resps(1);
        chk("mid_readback", got_q[base], 32'h10);

        // Random ops on four addresses against a scoreboard, random back-pressure.
        for (int i = 0; i < 4; i++) sb[i] = 32'hFFFF_FFF0 + i;
        base = got_q.size(); done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    logic [1:0] op;
                    int a;
                    logic [DW-1:0] d, old;
                    op = 2'($urandom_range(0, 3));
                    a = $urandom_range(0, 3);
                    d = $urandom;
                    old = sb[a];
                    exp_q.push_back(old);
                    if (op == WR) sb[a] = d;
                    else if (op == AD) sb[a] = old + d;
                    send(op, AW'(40 + a), d);
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        @(negedge clk);
                    end
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    resp_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        resp_rdy = 1'b1;
        wait_resps(300);
        for (int i = 0; i < 300; i++) chk("rand_resp", got_q[base+i], exp_q[i]);
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk("rand_ram", mem[40+i], sb[i]);
        chk("rdy_in_reset", rdy_bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
